// File: rtl/clk_div_gen_pkg.sv
// rtl/clk_div_gen_pkg.sv - shared types and defaults for the clock divider/generator
// Purpose: channel state enum and default parameter constants for clk_div_gen.
// Ports:   none (package).
// Build option: CLK_DIV_GEN_BURST_EN adds the BURST channel state.
package clk_div_gen_pkg;

   localparam int DEF_NCH     = 4;
   localparam int DEF_DIV_W   = 8;
   localparam int DEF_BURST_W = 8;

`ifdef CLK_DIV_GEN_BURST_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_BURST = 2'd3
   } chan_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } chan_state_e;
`endif

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one independent divided-clock channel
// Purpose: generates a 50% duty clock of period 2*hp with glitch-free
//          start/stop, and (CLK_DIV_GEN_BURST_EN) fixed-length bursts.
// Ports:   clk, rst          - system clock, async active-high reset
//          en                - free-run enable
//          div               - half-period in clk cycles (0 treated as 1)
//          burst_start       - one-cycle burst request (burst build only)
//          burst_len         - number of full periods in a burst
//          clk_out           - registered generated clock
//          tick              - pulse in the cycle clk_out rises
//          busy              - channel not idle
//          burst_done        - pulse in the cycle of the final burst fall
// Build option: CLK_DIV_GEN_BURST_EN enables burst mode.
module clk_div_chan
   import clk_div_gen_pkg::*;
#(
   parameter int DIV_W   = DEF_DIV_W,
   parameter int BURST_W = DEF_BURST_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [DIV_W-1:0]   div,
   input  logic               burst_start,
   input  logic [BURST_W-1:0] burst_len,
   output logic               clk_out,
   output logic               tick,
   output logic               busy,
   output logic               burst_done
);

   chan_state_e      state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] hp_q, hp_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;
   logic [DIV_W-1:0] div_eff;
   logic             wrap;

`ifdef CLK_DIV_GEN_BURST_EN
   logic [BURST_W-1:0] bcnt_q, bcnt_d;
   logic               done_q, done_d;
`else
   logic unused_burst;
   assign unused_burst = ^{burst_start, burst_len};
`endif

   assign div_eff = (div == '0) ? DIV_W'(1) : div;
   // Last cycle of the current phase: the toggle happens at this edge.
   assign wrap    = (cnt_q == hp_q - DIV_W'(1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hp_d    = hp_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
`ifdef CLK_DIV_GEN_BURST_EN
      bcnt_d  = bcnt_q;
      done_d  = 1'b0;
`endif
      if (state_q == ST_IDLE) begin
         cnt_d = '0;
`ifdef CLK_DIV_GEN_BURST_EN
         // Burst request wins over en; a zero-length burst completes at once.
         if (burst_start) begin
            if (burst_len == '0) begin
               done_d = 1'b1;
            end else begin
               state_d = ST_BURST;
               hp_d    = div_eff;
               bcnt_d  = burst_len;
            end
         end else
`endif
         if (en) begin
            state_d = ST_RUN;
            hp_d    = div_eff;
         end
      end else begin
         cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
         if (wrap) begin
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
            // New div only takes effect at a phase boundary.
            hp_d   = div_eff;
         end
         case (state_q)
            ST_RUN: begin
               if (!en) begin
                  if (!clk_q) begin
                     // Low phase: stop now, clk_out already low.
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                     clk_d   = 1'b0;
                     tick_d  = 1'b0;
                     hp_d    = hp_q;
                  end else begin
                     // High phase must finish at full length.
                     state_d = wrap ? ST_IDLE : ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (en) begin
                  state_d = ST_RUN;
               end else if (wrap) begin
                  state_d = ST_IDLE;
               end
            end
`ifdef CLK_DIV_GEN_BURST_EN
            ST_BURST: begin
               // Periods are counted on falling toggles.
               if (wrap && clk_q) begin
                  bcnt_d = bcnt_q - BURST_W'(1);
                  if (bcnt_q == BURST_W'(1)) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hp_q    <= DIV_W'(1);
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef CLK_DIV_GEN_BURST_EN
         bcnt_q  <= '0;
         done_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hp_q    <= hp_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
`ifdef CLK_DIV_GEN_BURST_EN
         bcnt_q  <= bcnt_d;
         done_q  <= done_d;
`endif
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;
   assign busy    = busy_q;
`ifdef CLK_DIV_GEN_BURST_EN
   assign burst_done = done_q;
`else
   assign burst_done = 1'b0;
`endif

endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel programmable clock divider/generator
// Purpose: NCH independent clk_div_chan instances sharing clk and rst.
// Ports:   clk, rst    - system clock, async active-high reset
//          en          - [NCH] per-channel enable
//          div         - [NCH*DIV_W] half-periods, channel c at [c*DIV_W +: DIV_W]
//          burst_start - [NCH] burst requests
//          burst_len   - [NCH*BURST_W] burst period counts
//          clk_out, tick, busy, burst_done - [NCH] per-channel outputs
// Build option: CLK_DIV_GEN_BURST_EN enables burst mode.
module clk_div_gen
   import clk_div_gen_pkg::*;
#(
   parameter int NCH     = DEF_NCH,
   parameter int DIV_W   = DEF_DIV_W,
   parameter int BURST_W = DEF_BURST_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         en,
   input  logic [NCH*DIV_W-1:0]   div,
   input  logic [NCH-1:0]         burst_start,
   input  logic [NCH*BURST_W-1:0] burst_len,
   output logic [NCH-1:0]         clk_out,
   output logic [NCH-1:0]         tick,
   output logic [NCH-1:0]         busy,
   output logic [NCH-1:0]         burst_done
);

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      clk_div_chan #(
         .DIV_W   (DIV_W),
         .BURST_W (BURST_W)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .en          (en[c]),
         .div         (div[c*DIV_W +: DIV_W]),
         .burst_start (burst_start[c]),
         .burst_len   (burst_len[c*BURST_W +: BURST_W]),
         .clk_out     (clk_out[c]),
         .tick        (tick[c]),
         .busy        (busy[c]),
         .burst_done  (burst_done[c])
      );
   end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter NCH, default 4, number of independent clock channels.
REQ-002 Parameter DIV_W, default 8, width of per-channel half-period value.
REQ-003 Parameter BURST_W, default 8, width of per-channel burst length.
REQ-004 clk  input  1  sole system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  NCH  per-channel free-run enable.
REQ-007 div  input  NCH*DIV_W  per-channel half-period in clk cycles, channel c at [c*DIV_W +: DIV_W].
REQ-008 burst_start  input  NCH  per-channel one-cycle burst request.
REQ-009 burst_len  input  NCH*BURST_W  per-channel burst period count.
REQ-010 clk_out  output  NCH  registered generated clocks.
REQ-011 tick  output  NCH  one-cycle pulse, same cycle as each clk_out rising transition.
REQ-012 busy  output  NCH  high when channel state is not IDLE.
REQ-013 burst_done  output  NCH  one-cycle pulse at burst completion.

Function
REQ-014 Each channel SHALL hold state IDLE, RUN, DRAIN or BURST, a half-period counter cnt (DIV_W bits) and a latched half-period hp.
REQ-015 hp SHALL equal div for the channel, with div=0 treated as 1, latched on leaving IDLE and at every clk_out toggle.
REQ-016 In RUN/BURST, cnt SHALL increment each cycle; when cnt==hp-1, clk_out SHALL toggle and cnt SHALL clear; output period is 2*hp cycles, 50% duty.
REQ-017 IDLE with en=1 sampled at edge k SHALL enter RUN with cnt=0; first clk_out rise at edge k+hp.
REQ-018 RUN with en=0 and clk_out=0 SHALL return to IDLE at that edge, clk_out remaining 0.
REQ-019 RUN with en=0 and clk_out=1 SHALL enter DRAIN, completing the current high phase unshortened; on the falling toggle SHALL enter IDLE.
REQ-020 DRAIN with en=1 SHALL return to RUN without altering toggle timing.
REQ-021 No clk_out high or low phase SHALL ever be shorter than hp cycles of the hp in force (no runt pulses).
REQ-022 A change of div mid-phase SHALL take effect only at the next toggle.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-024 rst=1 SHALL immediately force all channels to IDLE, cnt=0, hp=1, clk_out=0, tick=0, busy=0, burst_done=0, regardless of clk.
REQ-025 Reset asserted mid-period or mid-burst SHALL abandon the operation with no completion pulse.
REQ-026 After rst deassertion, a channel SHALL act only on inputs sampled at the first subsequent clk edge.

Configuration
REQ-027 Macro CLK_DIV_GEN_BURST_EN SHALL compile in burst mode; ports SHALL exist in both builds.
REQ-028 With macro: burst_start=1 in IDLE and burst_len=L>0 SHALL enter BURST, generate exactly L full clk_out periods, then enter IDLE and pulse burst_done in the cycle of the final falling toggle.
REQ-029 With macro: burst_len=0 SHALL pulse burst_done at the next edge with no clk_out activity and the channel remaining IDLE.
REQ-030 With macro: burst_start outside IDLE SHALL be ignored; en SHALL be ignored while in BURST; burst_start has priority over en in IDLE.
REQ-031 Without macro: burst_start and burst_len SHALL be ignored, burst_done tied 0, BURST state absent.

Structure
REQ-032 Package clk_div_gen_pkg SHALL hold the channel state enum and default parameter constants.
REQ-033 Per-channel logic SHALL be sub-module clk_div_chan, instantiated NCH times by generate loop in clk_div_gen.

Verification
REQ-034 Ch0 div=2, en=1 from reset release -> clk_out period 4 cycles, first rise 2 cycles after en sampled, tick each rise.
REQ-035 Ch1 div=0, en=1 -> clk_out toggles every cycle (period 2), identical to div=1.
REQ-036 Ch2 div=5, drop en 1 cycle into high phase -> high phase still 5 cycles, then IDLE, busy falls; drop en in low phase -> immediate IDLE.
REQ-037 Ch0 div=3 running, change div to 1 mid-phase -> current phase stays 3 cycles, subsequent phases 1 cycle.
REQ-038 Burst build, ch3 div=2 burst_len=4 -> exactly 4 rises, burst_done one cycle at 4th fall; burst_len=0 -> burst_done next cycle, no clk_out edge.
REQ-039 rst pulsed asynchronously mid-burst on all channels -> all outputs 0 immediately, no burst_done.
